sad_pixel_sequencer: RTL and testbench

- Upstream control and datapath stage for the SAD accumulator register.
- On a go pulse it walks two pixel memories over N_PIX addresses and computes |a-b| for each pixel pair.
- It drives the accumulator's clear, enable and next-value inputs, so the accumulator holds the final SAD when done pulses.
- It accepts one pixel pair per clock and relies on the 1-cycle synchronous read latency of the memories.

---
 rtl/sad_pixel_sequencer.sv | 84 ++++++++
 tb/tb_sad_pixel_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sad_pixel_sequencer.sv
// Sequencer and datapath for a sum-of-absolute-differences block: walks two pixel
// memories in lockstep and feeds |a-b| into an external accumulator register.
module sad_pixel_sequencer #(
    parameter int PIX_W  = 8,
    parameter int N_PIX  = 256,
    parameter int ADDR_W = 8,
    parameter int SUM_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    output logic [ADDR_W-1:0] addr,
    output logic              rd_en,
    input  logic [PIX_W-1:0]  pix_a,
    input  logic [PIX_W-1:0]  pix_b,
    input  logic [SUM_W-1:0]  sum_in,
    output logic              sum_clr,
    output logic              sum_en,
    output logic [SUM_W-1:0]  adder,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {IDLE, CLR, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              valid_reg;
    logic [PIX_W-1:0]  absdiff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            addr_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            // Read data arrives one cycle after the request, so the valid flag trails rd_en.
            valid_reg <= rd_en;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        rd_en      = 1'b0;
        sum_clr    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                busy      = 1'b0;
                addr_next = '0;
                if (go) state_next = CLR;
            end
            CLR: begin
                sum_clr    = 1'b1;
                addr_next  = '0;
                state_next = RUN;
            end
            RUN: begin
                rd_en = 1'b1;
                // Hold on the last address rather than wrapping.
                if (addr_reg == LAST_ADDR) state_next = DRAIN;
                else                       addr_next  = addr_reg + 1'b1;
            end
            DRAIN: state_next = DONE;
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign addr    = addr_reg;
    assign sum_en  = valid_reg;
    assign absdiff = (pix_a >= pix_b) ? (pix_a - pix_b) : (pix_b - pix_a);
    assign adder   = sum_en ? (sum_in + SUM_W'(absdiff)) : '0;

endmodule

// File: tb/tb_sad_pixel_sequencer.sv
// Directed bench: three sequencer instances (N_PIX = 4, 2, 1), each with its own
// synchronous-read pixel memories and accumulator register.
module tb_sad_pixel_sequencer;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        go;
    logic [2:0]        preload;
    logic [2:0][7:0]   addr;
    logic [2:0]        rd_en, sum_clr, sum_en, busy, done;
    logic [2:0][31:0]  adder;
    logic [2:0][31:0]  acc;
    logic [7:0]        mem_a [3][4];
    logic [7:0]        mem_b [3][4];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int NP = (gi == 0) ? 4 : ((gi == 1) ? 2 : 1);
        logic [7:0]  pa_r, pb_r;
        logic [31:0] acc_r;

        sad_pixel_sequencer #(.PIX_W(8), .N_PIX(NP), .ADDR_W(8), .SUM_W(32)) u_dut (
            .clk     (clk),
            .rst     (rst),
            .go      (go[gi]),
            .addr    (addr[gi]),
            .rd_en   (rd_en[gi]),
            .pix_a   (pa_r),
            .pix_b   (pb_r),
            .sum_in  (acc_r),
            .sum_clr (sum_clr[gi]),
            .sum_en  (sum_en[gi]),
            .adder   (adder[gi]),
            .busy    (busy[gi]),
            .done    (done[gi])
        );

        always @(posedge clk) begin
            if (rd_en[gi]) begin
                pa_r <= mem_a[gi][addr[gi][1:0]];
                pb_r <= mem_b[gi][addr[gi][1:0]];
            end
        end

        // External accumulator: not reset by rst, cleared only by sum_clr.
        always @(posedge clk) begin
            if (preload[gi])      acc_r <= 32'd999;
            else if (sum_clr[gi]) acc_r <= 32'd0;
            else if (sum_en[gi])  acc_r <= adder[gi];
        end

        assign acc[gi] = acc_r;
    end

    task automatic load4(input logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3);
        mem_a[0][0] = a0; mem_a[0][1] = a1; mem_a[0][2] = a2; mem_a[0][3] = a3;
        mem_b[0][0] = b0; mem_b[0][1] = b1; mem_b[0][2] = b2; mem_b[0][3] = b3;
    endtask

    // Pulses go on instance sel and observes it for 30 cycles; cycle 1 is the one after go is sampled.
    task automatic run_block(input int sel, input bit extra_go,
                             output int clr_at, output logic [7:0] clr_addr,
                             output int done_at, output int en_cnt,
                             output int done_cnt, output logic [31:0] res);
        clr_at = 0; clr_addr = '0; done_at = 0; en_cnt = 0; done_cnt = 0; res = '0;
        @(negedge clk); go[sel] = 1'b1;
        @(posedge clk);
        @(negedge clk); go[sel] = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (sum_clr[sel] && clr_at == 0) begin
                clr_at   = n;
                clr_addr = addr[sel];
            end
            if (sum_en[sel]) en_cnt++;
            if (done[sel]) begin
                done_cnt++;
                if (done_at == 0) begin
                    done_at = n;
                    res     = acc[sel];
                end
            end
            if (extra_go) go[sel] = (n == 3);
            @(negedge clk);
        end
        go[sel] = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (addr[i] !== 8'd0 || rd_en[i] !== 1'b0 || sum_clr[i] !== 1'b0 || sum_en[i] !== 1'b0 ||
                busy[i] !== 1'b0 || done[i] !== 1'b0 || adder[i] !== 32'd0) begin
                failures++;
                $display("FAIL reset_state inst=%0d addr=%0d rd_en=%b clr=%b en=%b busy=%b done=%b adder=%0d required all 0",
                         i, addr[i], rd_en[i], sum_clr[i], sum_en[i], busy[i], done[i], adder[i]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 3'b000) begin
            failures++;
            $display("FAIL idle_after_reset busy=%b required 000", busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int ca, da, ec, dc;
        logic [7:0] cad;
        logic [31:0] r;
        load4(8'd10, 8'd20, 8'd30, 8'd40, 8'd12, 8'd15, 8'd30, 8'd0);
        run_block(0, 1'b0, ca, cad, da, ec, dc, r);
        checks++;
        if (ca !== 1 || cad !== 8'd0) begin
            failures++;
            $display("FAIL basic_clr cycle=%0d addr=%0d required cycle=1 addr=0", ca, cad);
        end
        checks++;
        if (ec !== 4) begin
            failures++;
            $display("FAIL basic_en_count got=%0d required=4", ec);
        end
        checks++;
        if (da !== 7 || dc !== 1) begin
            failures++;
            $display("FAIL basic_done_latency at=%0d count=%0d required at=7 count=1", da, dc);
        end
        checks++;
        if (r !== 32'd47) begin
            failures++;
            $display("FAIL basic_sad got=%0d required=47", r);
        end
        $display("test_basic sad=%0d done_at=%0d", r, da);
    endtask

    task automatic test_reversed();
        int ca, da, ec, dc;
        logic [7:0] cad;
        logic [31:0] r;
        mem_a[1][0] = 8'd0;   mem_a[1][1] = 8'd255;
        mem_b[1][0] = 8'd255; mem_b[1][1] = 8'd0;
        run_block(1, 1'b0, ca, cad, da, ec, dc, r);
        checks++;
        if (r !== 32'd510 || da !== 5 || ec !== 2) begin
            failures++;
            $display("FAIL reversed_sad got=%0d done_at=%0d en=%0d required 510/5/2", r, da, ec);
        end
        $display("test_reversed sad=%0d", r);
    endtask

    task automatic test_preload();
        int ca, da, ec, dc;
        logic [7:0] cad;
        logic [31:0] r;
        load4(8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7);
        @(negedge clk); preload[0] = 1'b1;
        @(negedge clk); preload[0] = 1'b0;
        checks++;
        if (acc[0] !== 32'd999) begin
            failures++;
            $display("FAIL preload_acc got=%0d required=999", acc[0]);
        end
        run_block(0, 1'b0, ca, cad, da, ec, dc, r);
        checks++;
        if (r !== 32'd0 || dc !== 1) begin
            failures++;
            $display("FAIL preload_sad got=%0d dones=%0d required 0/1", r, dc);
        end
        $display("test_preload sad=%0d", r);
    endtask

    task automatic test_go_during_run();
        int ca, da, ec, dc;
        logic [7:0] cad;
        logic [31:0] r;
        load4(8'd10, 8'd20, 8'd30, 8'd40, 8'd12, 8'd15, 8'd30, 8'd0);
        run_block(0, 1'b1, ca, cad, da, ec, dc, r);
        checks++;
        if (dc !== 1 || ec !== 4 || r !== 32'd47 || da !== 7) begin
            failures++;
            $display("FAIL go_during_run dones=%0d en=%0d sad=%0d at=%0d required 1/4/47/7", dc, ec, r, da);
        end
        $display("test_go_during_run sad=%0d", r);
    endtask

    task automatic test_async_reset();
        int ca, da, ec, dc, stray;
        logic [7:0] cad;
        logic [31:0] r;
        load4(8'd10, 8'd20, 8'd30, 8'd40, 8'd12, 8'd15, 8'd30, 8'd0);
        @(negedge clk); go[0] = 1'b1;
        @(posedge clk);
        @(negedge clk); go[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy[0] !== 1'b1 || rd_en[0] !== 1'b1 || sum_en[0] !== 1'b1) begin
            failures++;
            $display("FAIL mid_run_state busy=%b rd_en=%b en=%b required 1/1/1", busy[0], rd_en[0], sum_en[0]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (busy[0] !== 1'b0 || rd_en[0] !== 1'b0 || sum_en[0] !== 1'b0 || done[0] !== 1'b0) begin
            failures++;
            $display("FAIL async_reset busy=%b rd_en=%b en=%b done=%b required 0", busy[0], rd_en[0], sum_en[0], done[0]);
        end
        @(negedge clk); rst = 1'b0;
        stray = 0;
        for (int n = 0; n < 10; n++) begin
            if (done[0] || busy[0]) stray++;
            @(negedge clk);
        end
        checks++;
        if (stray !== 0) begin
            failures++;
            $display("FAIL reset_no_done active_cycles=%0d required=0", stray);
        end
        run_block(0, 1'b0, ca, cad, da, ec, dc, r);
        checks++;
        if (r !== 32'd47 || da !== 7) begin
            failures++;
            $display("FAIL after_reset_sad got=%0d at=%0d required 47/7", r, da);
        end
        $display("test_async_reset sad=%0d", r);
    endtask

    task automatic test_back_to_back();
        logic [7:0]  next_a [3];
        logic [7:0]  next_b [3];
        logic [31:0] exp_sad [3];
        int k, last, enc;
        next_a[0] = 8'd100; next_b[0] = 8'd30;  exp_sad[0] = 32'd70;
        next_a[1] = 8'd5;   next_b[1] = 8'd200; exp_sad[1] = 32'd195;
        next_a[2] = 8'd9;   next_b[2] = 8'd9;   exp_sad[2] = 32'd0;
        mem_a[2][0] = next_a[0]; mem_b[2][0] = next_b[0];
        k = 0; last = 0; enc = 0;
        @(negedge clk); go[2] = 1'b1;
        for (int n = 1; n <= 40 && k < 3; n++) begin
            @(negedge clk);
            if (sum_en[2]) enc++;
            if (done[2]) begin
                checks++;
                if (acc[2] !== exp_sad[k]) begin
                    failures++;
                    $display("FAIL b2b_sad block=%0d got=%0d required=%0d", k, acc[2], exp_sad[k]);
                end
                if (k > 0) begin
                    checks++;
                    if (n - last !== 5) begin
                        failures++;
                        $display("FAIL b2b_period block=%0d got=%0d required=5", k, n - last);
                    end
                end
                $display("test_back_to_back block=%0d sad=%0d", k, acc[2]);
                last = n;
                k++;
                if (k < 3) begin
                    mem_a[2][0] = next_a[k];
                    mem_b[2][0] = next_b[k];
                end else begin
                    go[2] = 1'b0;
                end
            end
        end
        go[2] = 1'b0;
        checks++;
        if (k !== 3 || enc !== 3) begin
            failures++;
            $display("FAIL b2b_blocks dones=%0d en=%0d required 3/3", k, enc);
        end
    endtask

    initial begin
        rst     = 1'b1;
        go      = '0;
        preload = '0;
        test_reset();
        test_basic();
        test_reversed();
        test_preload();
        test_go_during_run();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
